// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral.
// Register word indices (addr[5:2]) and byte-lane helpers.
package gpio_pkg;

  localparam logic [3:0] GPIO_OUT  = 4'h0;
  localparam logic [3:0] GPIO_SET  = 4'h1;
  localparam logic [3:0] GPIO_CLR  = 4'h2;
  localparam logic [3:0] GPIO_TGL  = 4'h3;
  localparam logic [3:0] GPIO_DIR  = 4'h4;
  localparam logic [3:0] GPIO_IN   = 4'h5;
  localparam logic [3:0] GPIO_RISE = 4'h6;
  localparam logic [3:0] GPIO_FALL = 4'h7;
  localparam logic [3:0] GPIO_IRQ  = 4'h8;

  function automatic logic [31:0] lane_mask(
    input logic [3:0] wen
  );
    return {{8{wen[3]}}, {8{wen[2]}},
            {8{wen[1]}}, {8{wen[0]}}};
  endfunction

endpackage

// File: rtl/gpio_port_sync_edge.sv
// Input synchroniser chain with one extra history
// flop for rising/falling edge detection.
module gpio_sync_edge #(
  parameter int NUM_GPIO    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_GPIO-1:0] gpio_i,
  output logic [NUM_GPIO-1:0] sync_in,
  output logic [NUM_GPIO-1:0] rise_raw,
  output logic [NUM_GPIO-1:0] fall_raw
);

  logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] sync_q;
  logic [NUM_GPIO-1:0]                  prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign rise_raw = sync_in & ~prev_q;
  assign fall_raw = ~sync_in & prev_q;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: direction, set/clr/tgl,
// synchronised inputs and edge interrupts.
module gpio_port #(
  parameter int                  NUM_GPIO    = 6,
  parameter logic [3:0]          BASE_NIBBLE = 4'h9,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_GPIO-1:0] OUT_RESET   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [3:0]          wen,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [NUM_GPIO-1:0] gpio_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  import gpio_pkg::*;

  localparam int N = NUM_GPIO;

  logic         hit, wr_hit, rd_hit;
  logic [3:0]   sel;
  logic [31:0]  lanes;
  logic [N-1:0] wd, lm;

  logic [N-1:0] out_q, out_d;
  logic [N-1:0] dir_q, dir_d;
  logic [N-1:0] rise_q, rise_d;
  logic [N-1:0] fall_q, fall_d;
  logic [N-1:0] irq_q, irq_d;
  logic [31:0]  rdata_q, rdata_d;

  logic [N-1:0] sync_in, rise_raw, fall_raw;
  logic [N-1:0] w1c;
  logic         unused_bits;

  gpio_sync_edge #(
    .NUM_GPIO    (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .gpio_i   (gpio_i),
    .sync_in  (sync_in),
    .rise_raw (rise_raw),
    .fall_raw (fall_raw)
  );

  assign hit    = en && (addr[31:28] == BASE_NIBBLE);
  assign wr_hit = hit && (wen != 4'h0);
  assign rd_hit = hit && (wen == 4'h0);
  assign sel    = addr[5:2];
  assign lanes  = lane_mask(wen);
  assign lm     = lanes[N-1:0];
  assign wd     = wdata[N-1:0] & lm;

  assign unused_bits = ^{addr[27:6], addr[1:0],
                         wdata, lanes};

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (wr_hit) begin
      case (sel)
        GPIO_OUT:  out_d  = (out_q & ~lm) | wd;
        GPIO_SET:  out_d  = out_q | wd;
        GPIO_CLR:  out_d  = out_q & ~wd;
        GPIO_TGL:  out_d  = out_q ^ wd;
        GPIO_DIR:  dir_d  = (dir_q & ~lm) | wd;
        GPIO_RISE: rise_d = (rise_q & ~lm) | wd;
        GPIO_FALL: fall_d = (fall_q & ~lm) | wd;
        GPIO_IRQ:  w1c    = wd;
        default:   ;
      endcase
    end
    // new edges override a same-cycle clear
    irq_d = (irq_q & ~w1c)
          | (rise_raw & rise_q)
          | (fall_raw & fall_q);
  end

  always_comb begin
    rdata_d = '0;
    if (rd_hit) begin
      case (sel)
        GPIO_OUT:  rdata_d = 32'(out_q);
        GPIO_DIR:  rdata_d = 32'(dir_q);
        GPIO_IN:   rdata_d = 32'(sync_in);
        GPIO_RISE: rdata_d = 32'(rise_q);
        GPIO_FALL: rdata_d = 32'(fall_q);
        GPIO_IRQ:  rdata_d = 32'(irq_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= OUT_RESET;
      dir_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      irq_q   <= '0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq     = |irq_q;

endmodule

// File: tb/tb_gpio_port.sv
// Directed-vector bench for gpio_port with a
// 12-pin instance and 2 synchroniser stages.
module tb_gpio_port;

  localparam int N = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [3:0]   wen = 4'h0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic [N-1:0] gpio_i = '0;
  logic [N-1:0] gpio_o;
  logic [N-1:0] gpio_oe;
  logic         irq;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  gpio_port #(
    .NUM_GPIO    (N),
    .BASE_NIBBLE (4'h9),
    .SYNC_STAGES (2),
    .OUT_RESET   ('0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .wen     (wen),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic wr(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  w
  );
    @(negedge clk);
    en = 1'b1; wen = w; addr = a; wdata = d;
    @(negedge clk);
    en = 1'b0; wen = 4'h0;
  endtask

  task automatic rd(
    input  logic [31:0] a,
    output logic [31:0] d
  );
    @(negedge clk);
    en = 1'b1; wen = 4'h0; addr = a;
    @(negedge clk);
    en = 1'b0;
    d = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    chk("rst_out", 32'(gpio_o), 32'h0);
    chk("rst_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd(32'h9000_0000, rv); chk("rst_rd00", rv, 0);
    rd(32'h9000_0010, rv); chk("rst_rd10", rv, 0);
    rd(32'h9000_0020, rv); chk("rst_rd20", rv, 0);

    wr(32'h9000_0000, 32'h15, 4'hF);
    chk("out", 32'(gpio_o), 32'h15);
    wr(32'h9000_0004, 32'h22, 4'hF);
    chk("set", 32'(gpio_o), 32'h37);
    wr(32'h9000_0008, 32'h01, 4'hF);
    chk("clr", 32'(gpio_o), 32'h36);
    wr(32'h9000_000C, 32'h3F, 4'hF);
    chk("tgl", 32'(gpio_o), 32'h09);
    rd(32'h9000_0004, rv); chk("rd_set", rv, 0);
    chk("rd_idle", rdata, 0);

    wr(32'h9000_0000, 32'hFFFF_FFFF, 4'b0001);
    chk("lane0", 32'(gpio_o), 32'h0FF);
    rd(32'h9000_0000, rv); chk("rd_lane0", rv, 32'hFF);
    wr(32'h9000_0000, 32'hFFFF_FA00, 4'b0010);
    chk("lane1", 32'(gpio_o), 32'hAFF);
    wr(32'h9000_0004, 32'h0000_0100, 4'b0001);
    chk("set_lane", 32'(gpio_o), 32'hAFF);
    rd(32'h9000_0003, rv); chk("rd_misal", rv, 32'hAFF);

    wr(32'h9000_0010, 32'h3F, 4'hF);
    chk("dir", 32'(gpio_oe), 32'h3F);
    rd(32'h9000_0010, rv); chk("rd_dir", rv, 32'h3F);

    wr(32'h9000_0018, 32'h04, 4'hF);
    @(negedge clk);
    gpio_i[2] = 1'b1;
    @(negedge clk);
    chk("irq_t1", 32'(irq), 0);
    @(negedge clk);
    chk("irq_t2", 32'(irq), 0);
    @(negedge clk);
    chk("irq_t3", 32'(irq), 1);
    rd(32'h9000_0014, rv); chk("din", rv, 32'h4);
    rd(32'h9000_0020, rv); chk("sts", rv, 32'h4);
    wr(32'h9000_0020, 32'h04, 4'hF);
    chk("w1c", 32'(irq), 0);

    wr(32'h9000_001C, 32'h01, 4'hF);
    gpio_i[0] = 1'b1;
    idle(4);
    chk("no_fall", 32'(irq), 0);
    gpio_i[0] = 1'b0;
    @(negedge clk);
    wr(32'h9000_0020, 32'h01, 4'hF);
    chk("race_irq", 32'(irq), 1);
    rd(32'h9000_0020, rv); chk("race_sts", rv, 1);
    wr(32'h9000_0020, 32'h01, 4'hF);
    chk("race_clr", 32'(irq), 0);

    wr(32'h8000_0000, 32'h0, 4'hF);
    chk("miss_wr", 32'(gpio_o), 32'hAFF);
    rd(32'h8000_0010, rv); chk("miss_rd", rv, 0);
    wr(32'h9000_0024, 32'hFFF, 4'hF);
    rd(32'h9000_0024, rv); chk("rd_hole", rv, 0);

    @(negedge clk);
    en = 1'b1; wen = 4'h0; addr = 32'h9000_0010;
    @(negedge clk);
    en = 1'b0; reset = 1'b1;
    chk("pre_rst", rdata, 32'h3F);
    @(negedge clk);
    chk("mid_rdata", rdata, 0);
    chk("mid_oe", 32'(gpio_oe), 0);
    chk("mid_out", 32'(gpio_o), 0);
    en = 1'b1; wen = 4'hF;
    addr = 32'h9000_0000; wdata = 32'hFFF;
    @(negedge clk);
    en = 1'b0; wen = 4'h0; reset = 1'b0;
    chk("rst_wr", 32'(gpio_o), 0);
    idle(4);
    chk("post_irq", 32'(irq), 0);
    rd(32'h9000_0014, rv); chk("post_din", rv, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
